mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that lets the CPU core's instruction-fetch port and data (MEM-stage) port share one unified single-port memory with a req/ack handshake. It sits between `mips` and the memory in the SoC top level: it serializes accesses, returns read data to the correct requester, and raises a stall request to the pipeline controller while either port waits.

## Interface
- `ADDR_W`, 32, address width (matches `InstAddrBus`)
- `DATA_W`, 32, data width (matches `InstBus`)
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_ce_i`  in  1  fetch request; held high until `if_done_o`
- `if_addr_i`  in  ADDR_W  fetch address; stable while `if_ce_i` is high
- `if_inst_o`  out  DATA_W  fetched word; valid in the `if_done_o` cycle, held until the next fetch completes
- `if_done_o`  out  1  one-cycle pulse: fetch complete
- `d_ce_i`  in  1  data request; held high until `d_done_o`
- `d_we_i`  in  1  1 = write, 0 = read
- `d_sel_i`  in  4  byte enables
- `d_addr_i`  in  ADDR_W  data address
- `d_wdata_i`  in  DATA_W  write data
- `d_rdata_o`  out  DATA_W  read data; valid in the `d_done_o` cycle, held until the next data read completes
- `d_done_o`  out  1  one-cycle pulse: data access complete
- `stallreq_o`  out  1  pipeline stall request
- `mem_req_o`  out  1  memory request
- `mem_we_o`  out  1  memory write enable
- `mem_sel_o`  out  4  memory byte enables
- `mem_addr_o`  out  ADDR_W  memory address
- `mem_wdata_o`  out  DATA_W  memory write data
- `mem_rdata_i`  in  DATA_W  memory read data; sampled in the `mem_ack_i` cycle
- `mem_ack_i`  in  1  memory completion; honored only while `mem_req_o` = 1

## Operation
- FSM states: IDLE, IGRANT (fetch in flight), DGRANT (data in flight).
- IDLE: if `d_ce_i` is pending, go to DGRANT. Otherwise, if `if_ce_i` is pending, go to IGRANT. Otherwise, stay in IDLE.
- A request is "pending" when its ce is high and its done pulse is not asserted this cycle.
- Arbitration is fixed priority, data over fetch, because the data access belongs to the older instruction.
- Anti-starvation rule: when a DGRANT completes and a fetch is pending, the fetch is granted next, even if a new data request is pending.
- On grant, the requester's command is latched into the `mem_*_o` registers and `mem_req_o` is set to 1.
- The `mem_*_o` outputs stay constant until the cycle after `mem_ack_i`.
- Fetch accesses drive `mem_we_o` = 0 and `mem_sel_o` = 4'hF.
- On the `mem_ack_i` edge:
  - IGRANT: latch `mem_rdata_i` into `if_inst_o`; pulse `if_done_o` next cycle.
  - DGRANT read: latch `mem_rdata_i` into `d_rdata_o`; pulse `d_done_o` next cycle.
  - DGRANT write: `d_rdata_o` is unchanged; `d_done_o` still pulses.
- Back-to-back grants: on the ack edge, if another request is pending, go straight to the next grant state with new `mem_*_o` values. `mem_req_o` stays 1 and there is no IDLE bubble. Otherwise go to IDLE and set `mem_req_o` = 0.
- Flush / abandonment: if the owning requester drops ce while its access is in flight, the access still completes. This applies to writes as well; a write is never cancelled.
  - The done pulse and the `if_inst_o`/`d_rdata_o` update are suppressed for an abandoned access.
  - The abandoned state is tracked by a per-grant "live" flag, cleared when ce falls.
- `stallreq_o` = (`if_ce_i` & ~`if_done_o`) | (`d_ce_i` & ~`d_done_o`). This is combinational from the inputs and registered done flags.
- Reset values:
  - State = IDLE.
  - `mem_req_o`, `mem_we_o`, `if_done_o`, `d_done_o` = 0.
  - `mem_sel_o` = 0; `mem_addr_o`, `mem_wdata_o`, `if_inst_o`, `d_rdata_o` = 0.
- Reset mid-access: `mem_req_o` drops at the reset edge and no done pulse is generated. The memory must tolerate an abandoned request.

## Timing
- Cycle 0: request seen in IDLE. Cycle 1: `mem_req_o` = 1. Earliest `mem_ack_i` is in cycle 1. Cycle 2: done pulse. Minimum latency from request to done is 2 cycles; each memory wait state adds one cycle.
- Back-to-back: the second request's `mem_req_o` cycle immediately follows the first ack cycle. Sustained throughput is one access per cycle with a zero-wait memory.
- `mem_ack_i` while `mem_req_o` = 0 is ignored.
- The done pulse lasts exactly 1 cycle. A requester that keeps ce high after its done pulse is treated as a new request starting that cycle.

## Test plan
- **Lone fetch:** `if_ce_i`=1, `if_addr_i`=0x0000_0010, memory acks with 1 wait state and rdata 0x2401_0005.
  - `mem_req_o` is high for cycles 1–2.
  - `if_done_o` pulses in cycle 3 with `if_inst_o`=0x2401_0005.
  - `stallreq_o` is high for cycles 0–2.
- **Simultaneous requests:** fetch at 0x20 and data read at 0x100 arrive in the same cycle, zero-wait memory.
  - Data is granted first, then the fetch with no bubble.
  - `mem_addr_o` sequence is 0x100, 0x20.
  - `d_done_o` is in cycle 2, `if_done_o` in cycle 3.
- **Starvation guard:** data requests arrive continuously while a fetch is pending.
  - Grants alternate D, I, D, I.
  - No fetch waits more than one data access.
- **Byte write:** `d_we_i`=1, `d_sel_i`=4'b0010, addr 0x104, wdata 0x0000_AB00.
  - `mem_we_o`=1 and `mem_sel_o`=4'b0010 are held until ack.
  - `d_done_o` pulses.
  - `d_rdata_o` keeps its prior value.
- **Flush:** `if_ce_i` drops in cycle 1 while a fetch with 3 wait states is in flight.
  - `mem_req_o` is held until ack.
  - No `if_done_o` pulse; `if_inst_o` is unchanged.
  - FSM returns to IDLE.
- **Reset mid-access:** `rst`=1 during DGRANT.
  - Next cycle: `mem_req_o`=0, all outputs are at their reset values, state is IDLE.
  - A following fetch completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports (instruction fetch, data) and the
// unified memory port that mem_arbiter multiplexes between them.
// The slave modport is the arbiter's view; master is the surrounding
// system (requesters plus memory) as seen from outside the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch port
  logic              if_ce_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_inst_o;
  logic              if_done_o;

  // Data (MEM-stage) port
  logic              d_ce_i;
  logic              d_we_i;
  logic [3:0]        d_sel_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_done_o;

  // Pipeline stall request
  logic              stallreq_o;

  // Unified single-port memory
  logic              mem_req_o;
  logic              mem_we_o;
  logic [3:0]        mem_sel_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  modport slave (
    input  if_ce_i, if_addr_i,
    output if_inst_o, if_done_o,
    input  d_ce_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
    output d_rdata_o, d_done_o,
    output stallreq_o,
    output mem_req_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport master (
    output if_ce_i, if_addr_i,
    input  if_inst_o, if_done_o,
    output d_ce_i, d_we_i, d_sel_i, d_addr_i, d_wdata_i,
    input  d_rdata_o, d_done_o,
    input  stallreq_o,
    input  mem_req_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the CPU's fetch port
// and its data port. Data has priority from IDLE (it belongs to the older
// instruction); a completing data access hands over to a waiting fetch, so
// fetch never waits behind more than one data access. Back-to-back grants
// keep mem_req high with no idle bubble. An access whose requester drops ce
// while in flight still runs to completion on the memory, but its done
// pulse and read-data update are suppressed.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IGRANT = 2'd1;
  localparam logic [1:0] DGRANT = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              live;

  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] if_inst;
  logic              if_done;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;

  logic              if_pend;
  logic              d_pend;
  logic              acked;
  logic              owner_ce;
  logic              live_now;
  logic              grant_new;

  logic              cmd_we;
  logic [3:0]        cmd_sel;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  // A request in its done cycle is not pending; a ce still high after
  // that becomes a fresh request from the following cycle.
  assign if_pend  = bus.if_ce_i & ~if_done;
  assign d_pend   = bus.d_ce_i  & ~d_done;

  // Ack only counts while a request is actually outstanding.
  assign acked    = mem_req & bus.mem_ack_i;

  // The access in flight is still wanted while its owner keeps ce high.
  assign owner_ce = (state == IGRANT) ? bus.if_ce_i : bus.d_ce_i;
  assign live_now = live & owner_ce;

  // A new command is loaded either from IDLE or straight off an ack edge.
  assign grant_new = (state_nxt != IDLE) & ((state == IDLE) | acked);

  // Next-state: data before fetch from IDLE; on completion the other port
  // goes first. The finishing port itself is only eligible again if it
  // abandoned this access and has since raised ce for a new one.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_pend)
          state_nxt = DGRANT;
        else if (if_pend)
          state_nxt = IGRANT;
      end
      IGRANT: begin
        if (acked) begin
          if (d_pend)
            state_nxt = DGRANT;
          else if (if_pend & ~live)
            state_nxt = IGRANT;
          else
            state_nxt = IDLE;
        end
      end
      DGRANT: begin
        if (acked) begin
          if (if_pend)
            state_nxt = IGRANT;
          else if (d_pend & ~live)
            state_nxt = DGRANT;
          else
            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command for the grant being entered; fetches are always full-word reads.
  always_comb begin
    cmd_we    = 1'b0;
    cmd_sel   = 4'hF;
    cmd_addr  = bus.if_addr_i;
    cmd_wdata = '0;
    if (state_nxt == DGRANT) begin
      cmd_we    = bus.d_we_i;
      cmd_sel   = bus.d_sel_i;
      cmd_addr  = bus.d_addr_i;
      cmd_wdata = bus.d_wdata_i;
    end
  end

  // FSM, memory request, done pulses and the per-grant live flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      live    <= 1'b0;
      if_done <= 1'b0;
      d_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      mem_req <= (state_nxt != IDLE);
      if_done <= (state == IGRANT) & acked & live_now;
      d_done  <= (state == DGRANT) & acked & live_now;
      if (grant_new)
        live <= 1'b1;
      else if (state != IDLE)
        live <= live_now;
    end
  end

  // Memory command registers: loaded on grant, held until after the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_sel   <= 4'h0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_new) begin
      mem_we    <= cmd_we;
      mem_sel   <= cmd_sel;
      mem_addr  <= cmd_addr;
      mem_wdata <= cmd_wdata;
    end
  end

  // Read-data return: captured on the ack edge, only for live accesses;
  // writes leave d_rdata untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_inst <= '0;
      d_rdata <= '0;
    end else begin
      if ((state == IGRANT) & acked & live_now)
        if_inst <= bus.mem_rdata_i;
      if ((state == DGRANT) & acked & live_now & ~mem_we)
        d_rdata <= bus.mem_rdata_i;
    end
  end

  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_sel_o   = mem_sel;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;
  assign bus.if_inst_o   = if_inst;
  assign bus.if_done_o   = if_done;
  assign bus.d_rdata_o   = d_rdata;
  assign bus.d_done_o    = d_done;
  assign bus.stallreq_o  = if_pend | d_pend;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: behavioural memory with configurable wait
// states, requester tasks that push expected read data into per-port
// scoreboard queues, a done-pulse monitor that pops and compares, a
// table of single accesses and hand-written multi-cycle sequences.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem [0:255];
  int          mem_waits = 0;
  int          wcnt = 0;
  bit          stray_ack = 0;
  bit          pend_commit = 0;
  bit          c_we;
  logic [3:0]  c_sel;
  logic [31:0] c_addr, c_wdata;
  logic [31:0] ack_log[$];
  logic [31:0] exp_log[$];

  always @(negedge clk) begin
    if (pend_commit && c_we)
      for (int b = 0; b < 4; b++)
        if (c_sel[b]) mem[c_addr[9:2]][8*b +: 8] = c_wdata[8*b +: 8];
    pend_commit     = 0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = 32'hBAD0_BAD0;
    if (bus.mem_req_o) begin
      if (wcnt >= mem_waits) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = mem[bus.mem_addr_o[9:2]];
        pend_commit = 1;
        c_we    = bus.mem_we_o;
        c_sel   = bus.mem_sel_o;
        c_addr  = bus.mem_addr_o;
        c_wdata = bus.mem_wdata_o;
        ack_log.push_back(bus.mem_addr_o);
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
      if (stray_ack) bus.mem_ack_i = 1'b1;
    end
  end

  // ---------------- cycle trace (bit n = cycle n of a sequence) ----------------
  bit          tr_on = 0;
  int          t0 = 0;
  logic [15:0] tr_req, tr_idone, tr_ddone, tr_stall, tr_we, tr_sel;

  always @(negedge clk) begin : trace
    int idx;
    if (tr_on) begin
      idx = cyc - t0;
      if (idx >= 0 && idx < 16) begin
        tr_req[idx]   = bus.mem_req_o;
        tr_idone[idx] = bus.if_done_o;
        tr_ddone[idx] = bus.d_done_o;
        tr_stall[idx] = bus.stallreq_o;
        tr_we[idx]    = bus.mem_req_o & bus.mem_we_o;
        tr_sel[idx]   = bus.mem_req_o & (bus.mem_sel_o == 4'b0010);
      end
    end
  end

  task automatic start_trace();
    tr_req = '0; tr_idone = '0; tr_ddone = '0;
    tr_stall = '0; tr_we = '0; tr_sel = '0;
    ack_log.delete();
    exp_log.delete();
    t0 = cyc;
    tr_on = 1;
  endtask

  task automatic chk_log(input string name);
    chk({name, "_count"}, ack_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size(); i++)
      chk(name, (i < ack_log.size()) ? ack_log[i] : 32'hFFFF_FFFF, exp_log[i]);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  logic [31:0] if_hold = '0;
  logic [31:0] d_hold  = '0;
  int          if_done_cyc = 0;
  int          d_done_cyc  = 0;

  always @(negedge clk) begin
    if (bus.if_done_o === 1'b1) begin
      if_done_cyc = cyc;
      if (if_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_if_done: if_inst 0x%08h with no fetch outstanding", bus.if_inst_o);
      end else chk("if_inst", bus.if_inst_o, if_q.pop_front());
    end
    if (bus.d_done_o === 1'b1) begin
      d_done_cyc = cyc;
      if (d_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_d_done: d_rdata 0x%08h with no data access outstanding", bus.d_rdata_o);
      end else chk("d_rdata", bus.d_rdata_o, d_q.pop_front());
    end
  end

  // Fetch requester: holds ce until if_done, drops it the next cycle.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp);
    int n;
    bit got;
    if_q.push_back(exp);
    if_hold = exp;
    bus.if_addr_i = addr;
    bus.if_ce_i   = 1'b1;
    n = 0; got = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      if (bus.if_done_o) got = 1;
      n++;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL fetch_timeout: addr 0x%08h saw no if_done within 60 cycles", addr);
      void'(if_q.pop_back());
    end
    @(posedge clk); #1;
    bus.if_ce_i = 1'b0;
  endtask

  // Data requester: writes expect d_rdata to keep its previous value.
  task automatic data(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp);
    int n;
    bit got;
    if (!we) d_hold = exp;
    d_q.push_back(d_hold);
    bus.d_we_i    = we;
    bus.d_sel_i   = sel;
    bus.d_addr_i  = addr;
    bus.d_wdata_i = wdata;
    bus.d_ce_i    = 1'b1;
    n = 0; got = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      if (bus.d_done_o) got = 1;
      n++;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL data_timeout: addr 0x%08h saw no d_done within 60 cycles", addr);
      void'(d_q.pop_back());
    end
    @(posedge clk); #1;
    bus.d_ce_i = 1'b0;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] exp;   // read data; unused for writes (d_rdata holds)
  } vec_t;

  vec_t vec[7];

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int s;
    vec[0] = '{0, 0, 4'hF,    32'h0000_0040, 32'h0,         0, 32'hC0DE_0010};
    vec[1] = '{1, 0, 4'hF,    32'h0000_0044, 32'h0,         2, 32'hC0DE_0011};
    vec[2] = '{1, 1, 4'b0011, 32'h0000_0048, 32'h1234_5678, 0, 32'h0};
    vec[3] = '{1, 0, 4'hF,    32'h0000_0048, 32'h0,         0, 32'hC0DE_5678};
    vec[4] = '{1, 1, 4'hF,    32'h0000_004C, 32'hDEAD_BEEF, 3, 32'h0};
    vec[5] = '{0, 0, 4'hF,    32'h0000_004C, 32'h0,         1, 32'hDEAD_BEEF};
    vec[6] = '{1, 0, 4'hF,    32'h0000_03FC, 32'h0,         0, 32'hC0DE_00FF};

    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + i;
    mem[4] = 32'h2401_0005;

    rst = 1'b1;
    bus.if_ce_i = 1'b0; bus.if_addr_i = '0;
    bus.d_ce_i = 1'b0; bus.d_we_i = 1'b0; bus.d_sel_i = '0;
    bus.d_addr_i = '0; bus.d_wdata_i = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_req",  bus.mem_req_o,   0);
    chk("rst_mem_we",   bus.mem_we_o,    0);
    chk("rst_mem_sel",  bus.mem_sel_o,   0);
    chk("rst_mem_addr", bus.mem_addr_o,  0);
    chk("rst_dones",    {bus.if_done_o, bus.d_done_o}, 0);
    chk("rst_rdata",    bus.if_inst_o | bus.d_rdata_o | bus.mem_wdata_o, 0);
    chk("rst_stall",    bus.stallreq_o,  0);
    @(posedge clk); #1;
    rst = 1'b0;
    settle(1);

    // Table of single accesses with latency checks
    for (int i = 0; i < 7; i++) begin
      mem_waits = vec[i].waits;
      s = cyc;
      if (vec[i].is_d) begin
        data(vec[i].we, vec[i].sel, vec[i].addr, vec[i].wdata, vec[i].exp);
        chk($sformatf("vec%0d_latency", i), d_done_cyc - s, 2 + vec[i].waits);
      end else begin
        fetch(vec[i].addr, vec[i].exp);
        chk($sformatf("vec%0d_latency", i), if_done_cyc - s, 2 + vec[i].waits);
      end
    end

    // Lone fetch with one wait state
    mem_waits = 1;
    start_trace();
    fetch(32'h0000_0010, 32'h2401_0005);
    settle(1); tr_on = 0;
    chk("lone_req",   tr_req[4:0],   5'b00110);
    chk("lone_stall", tr_stall[4:0], 5'b00111);
    chk("lone_idone", tr_idone[4:0], 5'b01000);

    // Simultaneous fetch and data read: data first, no bubble
    mem_waits = 0;
    start_trace();
    fork
      fetch(32'h0000_0020, 32'hC0DE_0008);
      data(0, 4'hF, 32'h0000_0100, 32'h0, 32'hC0DE_0040);
    join
    settle(1); tr_on = 0;
    exp_log.push_back(32'h100); exp_log.push_back(32'h20);
    chk_log("simul_addr_seq");
    chk("simul_req",   tr_req[4:0],   5'b00110);
    chk("simul_ddone", tr_ddone[4:0], 5'b00100);
    chk("simul_idone", tr_idone[4:0], 5'b01000);

    // Starvation guard: continuous data requests interleave with fetches
    start_trace();
    fork
      begin
        data(0, 4'hF, 32'h0000_0200, 32'h0, 32'hC0DE_0080);
        data(0, 4'hF, 32'h0000_0204, 32'h0, 32'hC0DE_0081);
        data(0, 4'hF, 32'h0000_0208, 32'h0, 32'hC0DE_0082);
      end
      begin
        fetch(32'h0000_0300, 32'hC0DE_00C0);
        fetch(32'h0000_0304, 32'hC0DE_00C1);
      end
    join
    tr_on = 0;
    exp_log.push_back(32'h200); exp_log.push_back(32'h300);
    exp_log.push_back(32'h204); exp_log.push_back(32'h304);
    exp_log.push_back(32'h208);
    chk_log("starve_grant_seq");

    // Byte write: command held until ack, d_rdata unchanged, then read back
    mem_waits = 2;
    start_trace();
    data(1, 4'b0010, 32'h0000_0104, 32'h0000_AB00, 32'h0);
    settle(1); tr_on = 0;
    chk("bytew_we_held",  tr_we[5:0],    6'b001110);
    chk("bytew_sel_held", tr_sel[5:0],   6'b001110);
    chk("bytew_ddone",    tr_ddone[5:0], 6'b010000);
    mem_waits = 0;
    data(0, 4'hF, 32'h0000_0104, 32'h0, 32'hC0DE_AB41);

    // Stray ack while idle is ignored
    stray_ack = 1;
    start_trace();
    settle(3);
    stray_ack = 0;
    settle(1); tr_on = 0;
    chk("stray_req", tr_req[3:0], 4'b0000);
    s = cyc;
    fetch(32'h0000_0024, 32'hC0DE_0009);
    chk("stray_next_latency", if_done_cyc - s, 2);

    // Flush: fetch abandoned in cycle 1 with three wait states
    mem_waits = 3;
    bus.if_addr_i = 32'h0000_0050;
    bus.if_ce_i = 1'b1;
    start_trace();
    settle(1);
    bus.if_ce_i = 1'b0;
    settle(6); tr_on = 0;
    chk("flush_req",     tr_req[6:0],   7'b0011110);
    chk("flush_idone",   tr_idone[6:0], 7'b0000000);
    chk("flush_if_inst", bus.if_inst_o, if_hold);
    exp_log.push_back(32'h50);
    chk_log("flush_addr");
    mem_waits = 0;
    s = cyc;
    fetch(32'h0000_0054, 32'hC0DE_0015);
    chk("flush_next_latency", if_done_cyc - s, 2);

    // Reset in the middle of a data access
    mem_waits = 5;
    bus.d_we_i = 1'b0; bus.d_sel_i = 4'hF; bus.d_addr_i = 32'h0000_0060;
    bus.d_ce_i = 1'b1;
    start_trace();
    settle(2);
    rst = 1'b1;
    bus.d_ce_i = 1'b0;
    settle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_mem_req",   bus.mem_req_o,   0);
    chk("midrst_mem_addr",  bus.mem_addr_o,  0);
    chk("midrst_mem_sel",   bus.mem_sel_o,   0);
    chk("midrst_if_inst",   bus.if_inst_o,   0);
    chk("midrst_d_rdata",   bus.d_rdata_o,   0);
    chk("midrst_we_wdata",  {bus.mem_we_o, bus.mem_wdata_o[30:0]}, 0);
    if_hold = '0; d_hold = '0;
    settle(3); tr_on = 0;
    chk("midrst_req",   tr_req[5:0],   6'b000110);
    chk("midrst_ddone", tr_ddone[5:0], 6'b000000);
    mem_waits = 0;
    s = cyc;
    fetch(32'h0000_0010, 32'h2401_0005);
    chk("midrst_next_latency", if_done_cyc - s, 2);

    settle(2);
    chk("final_queues_empty", if_q.size() + d_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
